// File: rtl/rca_seq_defs_pkg.sv
// Shared definitions for the multi-cycle word adder: slice width and FSM state encodings.
package rca_seq_defs;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// Purely combinational W-bit ripple-carry adder built from a chain of full adders.
module ripple_carry_adder
    import rca_seq_defs::*;
#(
    parameter int W = SLICE_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W:0] chain;

    assign chain[0] = c;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_fa
            assign sum[gi]      = a[gi] ^ b[gi] ^ chain[gi];
            assign chain[gi+1]  = (a[gi] & b[gi]) | (chain[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign carry = chain[W];

endmodule

// File: rtl/rca_word_sequencer.sv
// Wide-word adder that reuses one 4-bit ripple-carry slice over NSLICE cycles, LSB slice first,
// with valid/ready handshakes on the operand and result sides.
module rca_word_sequencer
    import rca_seq_defs::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   out_sum_q, out_sum_d;
    logic               out_cout_q, out_cout_d;

    logic [SLICE_W-1:0] a_slices [NSLICE];
    logic [SLICE_W-1:0] b_slices [NSLICE];
    logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
    logic               slice_carry;
    logic [WIDTH-1:0]   res_upd;
    logic               last_slice;

    // res_upd is the result register with the current slice's sum merged in.
    generate
        for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
            assign a_slices[gi] = a_q[gi*SLICE_W +: SLICE_W];
            assign b_slices[gi] = b_q[gi*SLICE_W +: SLICE_W];
            assign res_upd[gi*SLICE_W +: SLICE_W] =
                (idx_q == IDX_W'(gi)) ? slice_sum : res_q[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    assign slice_a    = a_slices[idx_q];
    assign slice_b    = b_slices[idx_q];
    assign last_slice = (idx_q == IDX_W'(NSLICE - 1));

    ripple_carry_adder #(
        .W (SLICE_W)
    ) u_slice_adder (
        .a     (slice_a),
        .b     (slice_b),
        .c     (carry_q),
        .sum   (slice_sum),
        .carry (slice_carry)
    );

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        carry_d    = carry_q;
        out_sum_d  = out_sum_q;
        out_cout_d = out_cout_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    res_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d   = res_upd;
                carry_d = slice_carry;
                if (last_slice) begin
                    // Outputs only change here, so they hold across the next operation's RUN.
                    out_sum_d  = res_upd;
                    out_cout_d = slice_carry;
                    state_d    = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            carry_q    <= carry_d;
            out_sum_q  <= out_sum_d;
            out_cout_q <= out_cout_d;
        end
    end

endmodule

// File: tb/tb_rca_word_sequencer.sv
// Bench for rca_word_sequencer: directed scenarios on a 16-bit instance, random traffic on 4/16/32-bit instances.
module tb_rca_word_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic [2:0]  in_valid_v;
    logic [2:0]  in_ready_v;
    logic [2:0]  out_valid_v;
    logic [2:0]  out_ready_v;
    logic [2:0]  cout_v;
    logic [2:0]  busy_v;
    logic [3:0]  sum4;
    logic [15:0] sum16;
    logic [31:0] sum32;
    logic [31:0] osum [3];

    int checks;
    int failures;

    // Index 0: WIDTH=4, index 1: WIDTH=16, index 2: WIDTH=32
    rca_word_sequencer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_a(in_a[3:0]), .in_b(in_b[3:0]), .in_cin(in_cin),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .out_sum(sum4), .out_cout(cout_v[0]), .busy(busy_v[0])
    );

    rca_word_sequencer #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_cin(in_cin),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .out_sum(sum16), .out_cout(cout_v[1]), .busy(busy_v[1])
    );

    rca_word_sequencer #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .out_sum(sum32), .out_cout(cout_v[2]), .busy(busy_v[2])
    );

    assign osum[0] = {28'd0, sum4};
    assign osum[1] = {16'd0, sum16};
    assign osum[2] = sum32;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid_v[1], busy_v[1], cout_v[1], in_ready_v[1]} !== 4'b0000 || sum16 !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state got valid=%b busy=%b cout=%b in_ready=%b sum=%h required 0 0 0 0 0000",
                     out_valid_v[1], busy_v[1], cout_v[1], in_ready_v[1], sum16);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready_v !== 3'b111) begin
            failures++;
            $display("FAIL reset_release in_ready got=%b required=111", in_ready_v);
        end
        $display("reset: valid=%b busy=%b sum=%h in_ready=%b", out_valid_v[1], busy_v[1], sum16, in_ready_v);
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [15:0] exp_sum, input logic exp_cout, input string name);
        int lat;
        @(negedge clk);
        in_a = {16'd0, a};
        in_b = {16'd0, b};
        in_cin = cin;
        in_valid_v[1] = 1'b1;
        out_ready_v[1] = 1'b1;
        checks++;
        if (in_ready_v[1] !== 1'b1) begin
            failures++;
            $display("FAIL %s accept in_ready got=%b required=1", name, in_ready_v[1]);
        end
        @(posedge clk);
        #1;
        in_valid_v[1] = 1'b0;
        lat = 0;
        while (out_valid_v[1] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != 4) begin
            failures++;
            $display("FAIL %s latency got=%0d required=4", name, lat);
        end
        checks++;
        if (sum16 !== exp_sum || cout_v[1] !== exp_cout) begin
            failures++;
            $display("FAIL %s result got sum=%h cout=%b required sum=%h cout=%b",
                     name, sum16, cout_v[1], exp_sum, exp_cout);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid_v[1] !== 1'b0 || in_ready_v[1] !== 1'b1) begin
            failures++;
            $display("FAIL %s release got valid=%b in_ready=%b required valid=0 in_ready=1",
                     name, out_valid_v[1], in_ready_v[1]);
        end
        $display("%s: %h+%h+%b -> sum=%h cout=%b latency=%0d", name, a, b, cin, sum16, cout_v[1], lat);
    endtask

    task automatic test_back_pressure();
        int n;
        @(negedge clk);
        in_a = 32'h1111;
        in_b = 32'h2222;
        in_cin = 1'b0;
        in_valid_v[1] = 1'b1;
        out_ready_v[1] = 1'b0;
        @(posedge clk);
        #1;
        in_valid_v[1] = 1'b0;
        n = 0;
        while (out_valid_v[1] !== 1'b1 && n < 20) begin
            @(negedge clk);
            in_valid_v[1] = ~in_valid_v[1];
            in_a = $urandom;
            in_b = $urandom;
            checks++;
            if (in_ready_v[1] !== 1'b0) begin
                failures++;
                $display("FAIL bp_run in_ready got=%b required=0", in_ready_v[1]);
            end
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid_v[1] = ~in_valid_v[1];
            in_a = $urandom;
            in_b = $urandom;
            in_cin = 1'($urandom);
            checks++;
            if (out_valid_v[1] !== 1'b1 || sum16 !== 16'h3333 || cout_v[1] !== 1'b0 || in_ready_v[1] !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle %0d got valid=%b sum=%h cout=%b in_ready=%b required 1 3333 0 0",
                         i, out_valid_v[1], sum16, cout_v[1], in_ready_v[1]);
            end
        end
        @(negedge clk);
        in_valid_v[1] = 1'b0;
        out_ready_v[1] = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid_v[1] !== 1'b0 || sum16 !== 16'h3333) begin
            failures++;
            $display("FAIL bp_release got valid=%b sum=%h required valid=0 sum=3333", out_valid_v[1], sum16);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy_v[1] !== 1'b0 || out_valid_v[1] !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_ghost_op got busy=%b valid=%b required 0 0", busy_v[1], out_valid_v[1]);
        end
        $display("back_pressure: held 5 cycles, sum=%h", sum16);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        in_a = 32'h1234;
        in_b = 32'h4321;
        in_cin = 1'b1;
        in_valid_v[1] = 1'b1;
        out_ready_v[1] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[1] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy_v[1] !== 1'b1 || out_valid_v[1] !== 1'b0) begin
            failures++;
            $display("FAIL rst_run_pre got busy=%b valid=%b required 1 0", busy_v[1], out_valid_v[1]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready_v[1] !== 1'b0) begin
            failures++;
            $display("FAIL rst_run_in_ready got=%b required=0", in_ready_v[1]);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid_v[1] !== 1'b0 || busy_v[1] !== 1'b0 || sum16 !== 16'h0000 ||
            cout_v[1] !== 1'b0 || in_ready_v[1] !== 1'b1) begin
            failures++;
            $display("FAIL rst_run_abort got valid=%b busy=%b sum=%h cout=%b in_ready=%b required 0 0 0000 0 1",
                     out_valid_v[1], busy_v[1], sum16, cout_v[1], in_ready_v[1]);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (out_valid_v[1] !== 1'b0) begin
            failures++;
            $display("FAIL rst_run_no_result got valid=%b required=0", out_valid_v[1]);
        end
        $display("reset_mid_run: aborted, sum=%h", sum16);
        do_op(16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, "after_reset");
    endtask

    task automatic test_random(input int sel, input int width, input int nops);
        logic [32:0] exp_q [$];
        logic [32:0] exp_v;
        logic [32:0] act_v;
        logic [63:0] mask;
        logic [63:0] full;
        int sent;
        int got;
        int cyc;
        int budget;
        mask = (64'd1 << width) - 64'd1;
        budget = nops * (width / 4 + 2) * 10 + 100;
        sent = 0;
        got = 0;
        cyc = 0;
        while (got < nops && cyc < budget) begin
            @(negedge clk);
            cyc++;
            in_a = $urandom;
            in_b = $urandom;
            in_cin = 1'($urandom);
            in_valid_v[sel] = (sent < nops) && ($urandom_range(0, 3) != 0);
            out_ready_v[sel] = ($urandom_range(0, 3) != 0);
            if (in_valid_v[sel] && in_ready_v[sel]) begin
                full = (64'(in_a) & mask) + (64'(in_b) & mask) + 64'(in_cin);
                exp_q.push_back({full[width], full[31:0] & mask[31:0]});
                sent++;
            end
            if (out_valid_v[sel] && out_ready_v[sel]) begin
                act_v = {cout_v[sel], osum[sel]};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_w%0d unexpected result got=%h required=none", width, act_v);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (act_v !== exp_v) begin
                        failures++;
                        $display("FAIL rand_w%0d op %0d got cout/sum=%h required=%h", width, got, act_v, exp_v);
                    end else begin
                        $display("rand w%0d op %0d: cout/sum=%h", width, got, act_v);
                    end
                end
                got++;
            end
        end
        in_valid_v[sel] = 1'b0;
        out_ready_v[sel] = 1'b1;
        checks++;
        if (got != nops) begin
            failures++;
            $display("FAIL rand_w%0d timeout results got=%0d required=%0d", width, got, nops);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        in_a = '0;
        in_b = '0;
        in_cin = 1'b0;
        in_valid_v = 3'b000;
        out_ready_v = 3'b111;

        test_reset();
        do_op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, "zero");
        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "ripple");
        do_op(16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, "mixed");
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "all_ones");
        test_back_pressure();
        test_reset_mid_run();
        test_random(1, 16, 1000);
        test_random(0, 4, 1000);
        test_random(2, 32, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
